// File: rtl/comp_pkg.sv
// rtl/comp_pkg.sv - shared types and constants for the byte-serial comparator
//
// Purpose : FSM state type, byte width and cascade seed values used by
//           byte_serial_comparator and binary_comparator_8bit.
// Ports   : none (package).
package comp_pkg;

  localparam int BYTE_W = 8;

  // Cascade seed: "equal so far" before any byte has been seen.
  localparam logic CASC_B_BIG_INIT = 1'b0;
  localparam logic CASC_A_BIG_INIT = 1'b0;
  localparam logic CASC_EQ_INIT    = 1'b1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/binary_comparator_8bit.sv
// rtl/binary_comparator_8bit.sv - cascadable 8-bit magnitude comparator stage
//
// Purpose : compares one byte pair; when the bytes are equal the verdict of
//           the less-significant bytes (cascade inputs) is passed through.
// Ports   : a, b                               - byte operands
//           b_bigger_in, a_bigger_in, eq_in    - verdict from lower bytes
//           b_bigger, a_bigger, eq             - combined verdict (one-hot)
module binary_comparator_8bit
  import comp_pkg::*;
(
  input  logic [BYTE_W-1:0] a,
  input  logic [BYTE_W-1:0] b,
  input  logic              b_bigger_in,
  input  logic              a_bigger_in,
  input  logic              eq_in,
  output logic              b_bigger,
  output logic              a_bigger,
  output logic              eq
);

  always_comb begin
    b_bigger = b_bigger_in;
    a_bigger = a_bigger_in;
    eq       = eq_in;
    // A more significant byte that differs overrides anything below it.
    if (a > b) begin
      b_bigger = 1'b0;
      a_bigger = 1'b1;
      eq       = 1'b0;
    end else if (a < b) begin
      b_bigger = 1'b1;
      a_bigger = 1'b0;
      eq       = 1'b0;
    end
  end

endmodule

// File: rtl/byte_serial_comparator.sv
// rtl/byte_serial_comparator.sv - multi-byte magnitude comparator, one byte pair per handshake
//
// Purpose : compares two NBYTES-wide operands fed LSB first through a single
//           8-bit cascadable stage; registered three-way result plus a
//           one-cycle done pulse.
// Config  : COMP_SIGNED_EN - when defined, operands are two's complement
//           (bit 7 of the final byte pair is inverted before the stage).
// Ports   : clk, rst (sync, active-high)
//           start                      - begin a comparison (IDLE only)
//           a_byte, b_byte, byte_valid - byte pair input
//           byte_ready                 - byte pair accepted this cycle (RUN)
//           busy                       - high in RUN and DONE
//           done                       - one-cycle pulse, result valid
//           b_bigger, a_bigger, eq     - registered one-hot result
module byte_serial_comparator
  import comp_pkg::*;
#(
  parameter int NBYTES = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [BYTE_W-1:0] a_byte,
  input  logic [BYTE_W-1:0] b_byte,
  input  logic              byte_valid,
  output logic              byte_ready,
  output logic              busy,
  output logic              done,
  output logic              b_bigger,
  output logic              a_bigger,
  output logic              eq
);

  localparam int CNT_W = $clog2(NBYTES);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NBYTES - 1);

  state_t            state;
  logic [CNT_W-1:0]  cnt;
  logic              casc_b_big;
  logic              casc_a_big;
  logic              casc_eq;

  logic              last_byte;
  logic              accept;
  logic [BYTE_W-1:0] stage_a;
  logic [BYTE_W-1:0] stage_b;
  logic              stage_b_big;
  logic              stage_a_big;
  logic              stage_eq;

  assign last_byte = (cnt == LAST_IDX);
  // byte_ready is a registered decode of RUN, so accept has no path back
  // into byte_ready.
  assign accept    = byte_valid && byte_ready;

  always_comb begin
    stage_a = a_byte;
    stage_b = b_byte;
`ifdef COMP_SIGNED_EN
    // Flipping the sign bits of the top byte maps two's complement order
    // onto unsigned order; lower bytes are magnitude bits either way.
    if (last_byte) begin
      stage_a[BYTE_W-1] = ~a_byte[BYTE_W-1];
      stage_b[BYTE_W-1] = ~b_byte[BYTE_W-1];
    end
`endif
  end

  binary_comparator_8bit u_stage (
    .a           (stage_a),
    .b           (stage_b),
    .b_bigger_in (casc_b_big),
    .a_bigger_in (casc_a_big),
    .eq_in       (casc_eq),
    .b_bigger    (stage_b_big),
    .a_bigger    (stage_a_big),
    .eq          (stage_eq)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      casc_b_big <= CASC_B_BIG_INIT;
      casc_a_big <= CASC_A_BIG_INIT;
      casc_eq    <= CASC_EQ_INIT;
      b_bigger   <= CASC_B_BIG_INIT;
      a_bigger   <= CASC_A_BIG_INIT;
      eq         <= CASC_EQ_INIT;
      byte_ready <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state      <= RUN;
            cnt        <= '0;
            casc_b_big <= CASC_B_BIG_INIT;
            casc_a_big <= CASC_A_BIG_INIT;
            casc_eq    <= CASC_EQ_INIT;
            byte_ready <= 1'b1;
            busy       <= 1'b1;
          end
        end
        RUN: begin
          if (accept) begin
            casc_b_big <= stage_b_big;
            casc_a_big <= stage_a_big;
            casc_eq    <= stage_eq;
            if (last_byte) begin
              // Counter stays at NBYTES-1 so it never wraps.
              state      <= DONE;
              b_bigger   <= stage_b_big;
              a_bigger   <= stage_a_big;
              eq         <= stage_eq;
              byte_ready <= 1'b0;
              done       <= 1'b1;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        DONE: begin
          state <= IDLE;
          done  <= 1'b0;
          busy  <= 1'b0;
        end
        default: begin
          state      <= IDLE;
          byte_ready <= 1'b0;
          busy       <= 1'b0;
          done       <= 1'b0;
        end
      endcase
    end
  end

endmodule
